// File: rtl/mcu_debug_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_debug_ctrl
//  Description : Run/halt/single-step debug controller for a small MCU core.
//                Gates the core clock-enable, tracks the halt cause, supports
//                one address breakpoint and counts retired instructions.
//  Ports       : clk, reset      - rising-edge clock, async active-high reset
//                cmd_valid/cmd/cmd_data/cmd_ready - debug command handshake
//                instr_done/next_pc/hlt_exec      - retirement info from core
//                core_en, halted, halt_cause, step_done, instr_count - status
//  Revision    : 1.0 - initial release
// ============================================================================
module mcu_debug_ctrl #(
  parameter int RESET_HALTED = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  input  logic [7:0]       cmd_data,
  output logic             cmd_ready,
  input  logic             instr_done,
  input  logic [7:0]       next_pc,
  input  logic             hlt_exec,
  output logic             core_en,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic             step_done,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [1:0] c_st_run      = 2'd0;
  localparam logic [1:0] c_st_halt_req = 2'd1;
  localparam logic [1:0] c_st_step     = 2'd2;
  localparam logic [1:0] c_st_halted   = 2'd3;

  localparam logic [2:0] c_cmd_run   = 3'b001;
  localparam logic [2:0] c_cmd_halt  = 3'b010;
  localparam logic [2:0] c_cmd_step  = 3'b011;
  localparam logic [2:0] c_cmd_setbp = 3'b100;
  localparam logic [2:0] c_cmd_clrbp = 3'b101;

  localparam logic [1:0] c_cause_reset = 2'b00;
  localparam logic [1:0] c_cause_cmd   = 2'b01;
  localparam logic [1:0] c_cause_bp    = 2'b10;
  localparam logic [1:0] c_cause_hlt   = 2'b11;

  localparam logic [1:0] c_reset_state = (RESET_HALTED != 0) ? c_st_halted : c_st_run;

  logic [1:0]       r_state;
  logic [1:0]       r_halt_cause;
  logic             r_bp_en;
  logic [7:0]       r_bp_addr;
  logic [7:0]       r_steps_left;
  logic             r_step_done;
  logic [CNT_W-1:0] r_instr_count;

  logic [1:0] w_next_state;
  logic       w_enter_halt;
  logic [1:0] w_cause_next;
  logic [7:0] w_steps_next;
  logic       w_accept;
  logic       w_retire;
  logic       w_hlt_hit;
  logic       w_bp_hit;
  logic [1:0] w_trap_cause;

  // A retirement only counts while the core is enabled; anything reported
  // while parked in HALTED is spurious and dropped.
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_retire     = instr_done && (r_state != c_st_halted);
  assign w_hlt_hit    = w_retire && hlt_exec;
  // The breakpoint is only evaluated on a retirement, so resuming while
  // parked at bp_addr cannot re-trigger until an instruction has retired.
  assign w_bp_hit     = w_retire && r_bp_en && (next_pc == r_bp_addr);
  assign w_trap_cause = w_hlt_hit ? c_cause_hlt : c_cause_bp;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_reset_state;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    w_enter_halt = 1'b0;
    w_cause_next = r_halt_cause;
    w_steps_next = r_steps_left;
    case (r_state)
      c_st_run: begin
        if (w_hlt_hit || w_bp_hit) begin
          w_next_state = c_st_halted;
          w_enter_halt = 1'b1;
          w_cause_next = w_trap_cause;
        end else if (w_accept && (cmd == c_cmd_halt)) begin
          // A retirement in the same cycle is already a clean boundary.
          if (instr_done) begin
            w_next_state = c_st_halted;
            w_enter_halt = 1'b1;
            w_cause_next = c_cause_cmd;
          end else begin
            w_next_state = c_st_halt_req;
          end
        end
      end
      c_st_halt_req: begin
        if (w_retire) begin
          w_next_state = c_st_halted;
          w_enter_halt = 1'b1;
          w_cause_next = (w_hlt_hit || w_bp_hit) ? w_trap_cause : c_cause_cmd;
        end
      end
      c_st_step: begin
        if (w_retire) begin
          w_steps_next = r_steps_left - 8'd1;
          if (w_hlt_hit || w_bp_hit) begin
            w_next_state = c_st_halted;
            w_enter_halt = 1'b1;
            w_cause_next = w_trap_cause;
          end else if (r_steps_left == 8'd1) begin
            w_next_state = c_st_halted;
            w_enter_halt = 1'b1;
            w_cause_next = c_cause_cmd;
          end
        end
      end
      default: begin // c_st_halted
        if (w_accept && (cmd == c_cmd_run)) begin
          w_next_state = c_st_run;
        end else if (w_accept && (cmd == c_cmd_step)) begin
          w_next_state = c_st_step;
          w_steps_next = (cmd_data == 8'd0) ? 8'd1 : cmd_data;
        end
      end
    endcase
  end

  // Output logic
  always_comb begin
    core_en   = (r_state != c_st_halted);
    halted    = (r_state == c_st_halted);
    cmd_ready = (r_state == c_st_run) || (r_state == c_st_halted);
  end

  // Debug datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_halt_cause  <= c_cause_reset;
      r_bp_en       <= 1'b0;
      r_bp_addr     <= 8'd0;
      r_steps_left  <= 8'd0;
      r_step_done   <= 1'b0;
      r_instr_count <= '0;
    end else begin
      if (w_enter_halt) begin
        r_halt_cause <= w_cause_next;
      end
      if (w_accept && (cmd == c_cmd_setbp)) begin
        r_bp_addr <= cmd_data;
        r_bp_en   <= 1'b1;
      end else if (w_accept && (cmd == c_cmd_clrbp)) begin
        r_bp_en <= 1'b0;
      end
      r_steps_left <= w_steps_next;
      // Asserted together with the STEP->HALTED state update, so it is seen
      // in the first halted cycle only.
      r_step_done  <= (r_state == c_st_step) && (w_next_state == c_st_halted);
      if (w_retire) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

  assign halt_cause  = r_halt_cause;
  assign step_done   = r_step_done;
  assign instr_count = r_instr_count;

endmodule
`default_nettype wire
